// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_reg
//  Purpose  : Generic inter-stage pipeline register (IF/ID, ID/EX, EX/MEM...)
//             carrying a PC and a payload with a valid/ready handshake.
//             A 2-entry skid buffer (main = head, skid = overflow) gives full
//             throughput while keeping in_ready independent of out_ready.
//             freeze holds everything in place. flush squashes all held
//             entries to a bubble.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    PC_W      width of the PC field
//    DATA_W    width of the payload (instruction / control bundle)
//    BUBBLE    payload driven on out_data when no valid entry (NOP encoding)
//    CNT_W     width of the performance counters
//  Ports
//    clk        in   1       rising-edge clock
//    rst        in   1       asynchronous reset, active-low
//    flush      in   1       synchronous squash of all held entries
//    freeze     in   1       synchronous hold: no accept, no drain
//    in_valid   in   1       upstream entry valid
//    in_ready   out  1       stage can accept this cycle
//    in_pc      in   PC_W    upstream PC
//    in_data    in   DATA_W  upstream payload
//    out_valid  out  1       entry presented downstream
//    out_ready  in   1       downstream accepts
//    out_pc     out  PC_W    PC of head entry, 0 when !out_valid
//    out_data   out  DATA_W  payload of head entry, BUBBLE when !out_valid
//    stall_cnt  out  CNT_W   stall-cycle count
//    flush_cnt  out  CNT_W   flush-event count
//  Configuration macro
//    PIPE_PERF_CNT_EN  defined: saturating stall/flush counters are built.
//                      undefined: stall_cnt and flush_cnt are tied to 0.
// ============================================================================
module pipe_stage_reg #(
  parameter int                 PC_W   = 32,
  parameter int                 DATA_W = 32,
  parameter logic [DATA_W-1:0]  BUBBLE = '0,
  parameter int                 CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // --------------------------------------------------------------------------
  // Occupancy state: EMPTY (no entry), ONE (main only), FULL (main + skid)
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t              state_q,     state_d;
  logic [PC_W-1:0]     main_pc_q,   main_pc_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [PC_W-1:0]     skid_pc_q,   skid_pc_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;

  logic                in_ready_w;
  logic                out_valid_w;
  logic                accept_w;
  logic                drain_w;

  // --------------------------------------------------------------------------
  // Handshake. in_ready depends only on state and the local controls, never
  // on out_ready, so no combinational path runs back through the stage.
  // --------------------------------------------------------------------------
  assign in_ready_w  = (state_q != ST_FULL) & ~freeze & ~flush;
  assign out_valid_w = (state_q != ST_EMPTY) & ~freeze;
  assign accept_w    = in_valid & in_ready_w;
  assign drain_w     = out_valid_w & out_ready;

  assign in_ready  = in_ready_w;
  assign out_valid = out_valid_w;

  // Head entry is masked to a bubble whenever nothing is presented.
  assign out_pc   = out_valid_w ? main_pc_q   : '0;
  assign out_data = out_valid_w ? main_data_q : BUBBLE;

  // --------------------------------------------------------------------------
  // Next-state / datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    main_pc_d   = main_pc_q;
    main_data_d = main_data_q;
    skid_pc_d   = skid_pc_q;
    skid_data_d = skid_data_q;

    if (flush) begin
      // flush wins over freeze and voids any same-cycle transfer
      state_d     = ST_EMPTY;
      main_pc_d   = '0;
      main_data_d = BUBBLE;
      skid_pc_d   = '0;
      skid_data_d = BUBBLE;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept_w) begin
            state_d     = ST_ONE;
            main_pc_d   = in_pc;
            main_data_d = in_data;
          end
        end

        ST_ONE: begin
          if (accept_w && drain_w) begin
            // head leaves and the new entry replaces it in one cycle
            main_pc_d   = in_pc;
            main_data_d = in_data;
          end else if (accept_w) begin
            // downstream stalled: park the new entry behind the head
            state_d     = ST_FULL;
            skid_pc_d   = in_pc;
            skid_data_d = in_data;
          end else if (drain_w) begin
            state_d     = ST_EMPTY;
          end
        end

        ST_FULL: begin
          // in_ready is low here, so only a drain can change anything
          if (drain_w) begin
            state_d     = ST_ONE;
            main_pc_d   = skid_pc_q;
            main_data_d = skid_data_q;
          end
        end

        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_EMPTY;
      main_pc_q   <= '0;
      main_data_q <= BUBBLE;
      skid_pc_q   <= '0;
      skid_data_q <= BUBBLE;
    end else begin
      state_q     <= state_d;
      main_pc_q   <= main_pc_d;
      main_data_q <= main_data_d;
      skid_pc_q   <= skid_pc_d;
      skid_data_q <= skid_data_d;
    end
  end

  // --------------------------------------------------------------------------
  // Performance counters
  // --------------------------------------------------------------------------
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             stall_ev_w;

  // A held entry that cannot leave this cycle; flush cycles count as flushes.
  assign stall_ev_w = (state_q != ST_EMPTY) & (freeze | ~out_ready) & ~flush;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_ev_w && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage_reg
//  Purpose  : Self-checking bench for pipe_stage_reg. A queue-based model of
//             the stage is compared against the DUT on every falling edge;
//             directed scenarios add hand-computed literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

  localparam int          PC_W   = 32;
  localparam int          DATA_W = 32;
  localparam int          CNT_W  = 16;
  localparam logic [31:0] BUBBLE = 32'h0000_0013;
  localparam logic [31:0] MASK   = 32'hDEAD_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush, freeze, in_valid, out_ready;
  logic [PC_W-1:0]   in_pc;
  logic [DATA_W-1:0] in_data;
  logic              in_ready, out_valid;
  logic [PC_W-1:0]   out_pc;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .PC_W   (PC_W),
    .DATA_W (DATA_W),
    .BUBBLE (BUBBLE),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .freeze    (freeze),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_data  (out_data),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

`ifdef PIPE_PERF_CNT_EN
  // Narrow-counter copy sharing the same stimulus, for saturation checks.
  logic              s_in_ready, s_out_valid;
  logic [PC_W-1:0]   s_out_pc;
  logic [DATA_W-1:0] s_out_data;
  logic [1:0]        s_stall_cnt, s_flush_cnt;

  pipe_stage_reg #(
    .PC_W   (PC_W),
    .DATA_W (DATA_W),
    .BUBBLE (BUBBLE),
    .CNT_W  (2)
  ) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .freeze    (freeze),
    .in_valid  (in_valid),
    .in_ready  (s_in_ready),
    .in_pc     (in_pc),
    .in_data   (in_data),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .out_pc    (s_out_pc),
    .out_data  (s_out_data),
    .stall_cnt (s_stall_cnt),
    .flush_cnt (s_flush_cnt)
  );
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Model: the stage is a FIFO of at most two {pc,data} entries.
  // --------------------------------------------------------------------------
  logic [63:0] mq[$];
  int          m_stall = 0;
  int          m_flush = 0;
  localparam int CMAX = (1 << CNT_W) - 1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_stall = 0;
      m_flush = 0;
    end else if (flush) begin
      mq.delete();
      if (m_flush < CMAX) m_flush = m_flush + 1;
    end else begin
      bit acc, drn;
      if (mq.size() > 0 && (freeze || !out_ready) && m_stall < CMAX) m_stall = m_stall + 1;
      acc = in_valid && (mq.size() < 2) && !freeze;
      drn = (mq.size() > 0) && !freeze && out_ready;
      if (drn) void'(mq.pop_front());
      if (acc) mq.push_back({in_pc, in_data});
    end
  end

  // Per-cycle comparison, mid-cycle with inputs stable.
  always @(negedge clk) begin
    logic              e_ir, e_ov;
    logic [PC_W-1:0]   e_pc;
    logic [DATA_W-1:0] e_dat;
    logic [63:0]       head;
    head  = (mq.size() > 0) ? mq[0] : 64'd0;
    e_ir  = (mq.size() < 2) && !freeze && !flush;
    e_ov  = (mq.size() > 0) && !freeze;
    e_pc  = e_ov ? head[63:32] : '0;
    e_dat = e_ov ? head[31:0]  : BUBBLE;
    chk("cyc_in_ready",  64'(in_ready),  64'(e_ir));
    chk("cyc_out_valid", 64'(out_valid), 64'(e_ov));
    chk("cyc_out_pc",    64'(out_pc),    64'(e_pc));
    chk("cyc_out_data",  64'(out_data),  64'(e_dat));
`ifdef PIPE_PERF_CNT_EN
    chk("cyc_stall_cnt", 64'(stall_cnt), 64'(m_stall));
    chk("cyc_flush_cnt", 64'(flush_cnt), 64'(m_flush));
    chk("cyc_sat_stall", 64'(s_stall_cnt), 64'((m_stall > 3) ? 3 : m_stall));
`else
    chk("cyc_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("cyc_flush_cnt", 64'(flush_cnt), 64'd0);
`endif
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge,
  // literal checks happen 1 unit after that.
  // --------------------------------------------------------------------------
  task automatic drive(input logic v, input logic [31:0] pc, input logic ordy,
                       input logic frz, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_data   = pc ^ MASK;
    out_ready = ordy;
    freeze    = frz;
    flush     = fl;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_head(input string name, input logic [31:0] pc);
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
    chk({name, "_pc"},    64'(out_pc),    64'(pc));
    chk({name, "_data"},  64'(out_data),  64'(pc ^ MASK));
  endtask

  task automatic expect_bubble(input string name);
    chk({name, "_valid"}, 64'(out_valid), 64'd0);
    chk({name, "_pc"},    64'(out_pc),    64'd0);
    chk({name, "_data"},  64'(out_data),  64'(BUBBLE));
  endtask

  // Fill to FULL with pc0, pc0+4 while downstream is stalled.
  task automatic fill2(input logic [31:0] pc0);
    drive(1'b1, pc0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, pc0 + 32'd4, 1'b0, 1'b0, 1'b0);
    step();
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    expect_bubble("reset");
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    step();
    step();
    rst = 1'b1;

    // Streaming at full rate
    drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
    expect_bubble("stream0");
    step();
    drive(1'b1, 32'h104, 1'b1, 1'b0, 1'b0);
    expect_head("stream1", 32'h100);
    chk("stream1_in_ready", 64'(in_ready), 64'd1);
    step();
    drive(1'b1, 32'h108, 1'b1, 1'b0, 1'b0);
    expect_head("stream2", 32'h104);
    chk("stream2_in_ready", 64'(in_ready), 64'd1);
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    expect_head("stream3", 32'h108);
    step();
    expect_bubble("stream_end");

    // Backpressure
    fill2(32'h200);
    drive(1'b1, 32'h2F0, 1'b0, 1'b0, 1'b0);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    expect_head("bp_hold", 32'h200);
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    expect_head("bp_out0", 32'h200);
    step();
    expect_head("bp_out1", 32'h204);
    step();
    expect_bubble("bp_end");

    // Freeze with FULL
    fill2(32'h300);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h3F0, 1'b1, 1'b1, 1'b0);
      chk("frz_in_ready", 64'(in_ready), 64'd0);
      expect_bubble("frz");
      step();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    expect_head("frz_out0", 32'h300);
    step();
    expect_head("frz_out1", 32'h304);
    step();
    expect_bubble("frz_end");

    // Flush with FULL, then flush+freeze with FULL
    fill2(32'h380);
    drive(1'b1, 32'h400, 1'b1, 1'b0, 1'b1);
    chk("fl_in_ready", 64'(in_ready), 64'd0);
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    expect_bubble("fl_after");
    step();
    expect_bubble("fl_after2");

    fill2(32'h500);
    drive(1'b1, 32'h400, 1'b1, 1'b1, 1'b1);
    chk("flfz_in_ready", 64'(in_ready), 64'd0);
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    expect_bubble("flfz_after");
    step();
    expect_bubble("flfz_after2");

`ifdef PIPE_PERF_CNT_EN
    // Counters from a clean reset: 5 stalls in ONE, then 2 flushes
    rst = 1'b0;
    #1;
    rst = 1'b1;
    drive(1'b1, 32'h700, 1'b0, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      step();
    end
    chk("perf_stall5", 64'(stall_cnt), 64'd5);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    step();
    step();
    chk("perf_stall_after_fl", 64'(stall_cnt), 64'd5);
    chk("perf_flush2", 64'(flush_cnt), 64'd2);
    drive(1'b1, 32'h704, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    chk("perf_stall6", 64'(stall_cnt), 64'd6);
    chk("perf_sat_stall", 64'(s_stall_cnt), 64'd3);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
`endif

    // Asynchronous reset while FULL
    fill2(32'h800);
    drive(1'b1, 32'h900, 1'b0, 1'b0, 1'b0);
    expect_head("rst_pre", 32'h800);
    rst = 1'b0;
    #1;
    expect_bubble("rst_mid");
`ifdef PIPE_PERF_CNT_EN
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    step();
    rst = 1'b1;
    drive(1'b1, 32'h900, 1'b1, 1'b0, 1'b0);
    chk("rst_rel_in_ready", 64'(in_ready), 64'd1);
    expect_bubble("rst_rel");
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    expect_head("rst_first", 32'h900);
    step();
    expect_bubble("rst_end");
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
